// File: rtl/cpu.sv
// rtl/cpu.sv - single-bus 32-bit datapath with register file, Z/HI/LO, ports, CON and internal RAM
module cpu #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 512
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             IncPC,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             R0in,   R1in,   R2in,   R3in,
  input  logic             R4in,   R5in,   R6in,   R7in,
  input  logic             R8in,   R9in,   R10in,  R11in,
  input  logic             R12in,  R13in,  R14in,  R15in,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin,
  input  logic             Rout,
  input  logic             BAout,
  input  logic             MARin,
  input  logic             MDRout,
  input  logic             MDRin,
  input  logic             memRead,
  input  logic             ramEnable,
  input  logic             PCin,
  input  logic             PCout,
  input  logic             ADD,
  input  logic             Zin,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Yin,
  input  logic             IRin,
  input  logic             Cout,
  input  logic [WIDTH-1:0] InPortData,
  input  logic             InPort_Out,
  output logic [WIDTH-1:0] OutPortData,
  input  logic             OutPort_In,
  input  logic             CONin,
  output logic             CON
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0]   regs [16];
  logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   ram [MEM_DEPTH];

  logic [15:0]        r_out, r_in;
  logic [3:0]         ra, rb, rc, sel;
  logic [1:0]         c2;
  logic [WIDTH-1:0]   c_ext;
  logic [WIDTH-1:0]   bus, reg_val, sum, ram_rd;
  logic               reg_drv, con_next;
  logic [AW-1:0]      ram_addr;
  logic               unused_bits;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in  = {R15in,  R14in,  R13in,  R12in,  R11in,  R10in,  R9in,  R8in,
                  R7in,   R6in,   R5in,   R4in,   R3in,   R2in,   R1in,  R0in};

  assign ra    = ir[26:23];
  assign rb    = ir[22:19];
  assign rc    = ir[18:15];
  assign c2    = ir[20:19];
  assign c_ext = {{(WIDTH-19){ir[18]}}, ir[18:0]};
  assign sel   = Gra ? ra : (Grb ? rb : rc);

  // MAR bits above the RAM index are ignored, so addresses wrap
  assign ram_addr    = mar[AW-1:0];
  assign ram_rd      = ram[ram_addr];
  assign sum         = y + bus;
  assign unused_bits = ^{ir[31:27], mar[WIDTH-1:AW]};

  always_comb begin
    reg_drv = 1'b0;
    reg_val = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) begin
        reg_drv = 1'b1;
        reg_val = regs[i];
      end
    end
    if (!reg_drv && Rout) begin
      reg_drv = 1'b1;
      reg_val = regs[sel];
    end else if (!reg_drv && BAout) begin
      reg_drv = 1'b1;
      reg_val = (sel == 4'd0) ? '0 : regs[sel];
    end
  end

  always_comb begin
    bus = '0;
    if (reg_drv)         bus = reg_val;
    else if (PCout)      bus = pc;
    else if (MDRout)     bus = mdr;
    else if (Zhighout)   bus = z[2*WIDTH-1:WIDTH];
    else if (Zlowout)    bus = z[WIDTH-1:0];
    else if (HIout)      bus = hi;
    else if (LOout)      bus = lo;
    else if (InPort_Out) bus = InPortData;
    else if (Cout)       bus = c_ext;
  end

  always_comb begin
    con_next = 1'b0;
    case (c2)
      2'b00:   con_next = (bus == '0);
      2'b01:   con_next = (bus != '0);
      2'b10:   con_next = !bus[WIDTH-1] && (bus != '0);
      default: con_next = bus[WIDTH-1];
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i] || (Rin && (sel == 4'(i)))) regs[i] <= bus;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc          <= '0;
      ir          <= '0;
      mar         <= '0;
      mdr         <= '0;
      y           <= '0;
      z           <= '0;
      hi          <= '0;
      lo          <= '0;
      OutPortData <= '0;
      CON         <= 1'b0;
    end else begin
      if (IncPC)     pc <= pc + 1'b1;
      else if (PCin) pc <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) begin
        if (!memRead)       mdr <= bus;
        else if (ramEnable) mdr <= ram_rd;
      end
      if (Yin)  y  <= bus;
      if (Zin)  z  <= {{WIDTH{1'b0}}, ADD ? sum : bus};
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (OutPort_In) OutPortData <= bus;
      if (CONin)      CON <= con_next;
    end
  end

  // RAM is deliberately outside the reset domain
  always_ff @(posedge clock) begin
    if (ramEnable && !memRead) ram[ram_addr] <= mdr;
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) ram[i] = '0;
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for the cpu datapath
module tb_cpu;

  logic        clock = 1'b0;
  logic        clear;
  logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout, MARin, MDRout, MDRin;
  logic        memRead, ramEnable, PCin, PCout, ADD, Zin, Zhighout, Zlowout;
  logic        HIin, LOin, HIout, LOout, Yin, IRin, Cout, InPort_Out, OutPort_In, CONin;
  logic [15:0] rout_v, rin_v;
  logic [31:0] InPortData, OutPortData;
  logic        CON;
  int          checks = 0;
  int          failures = 0;

  cpu dut (
    .clock(clock), .clear(clear), .IncPC(IncPC),
    .R0out(rout_v[0]),   .R1out(rout_v[1]),   .R2out(rout_v[2]),   .R3out(rout_v[3]),
    .R4out(rout_v[4]),   .R5out(rout_v[5]),   .R6out(rout_v[6]),   .R7out(rout_v[7]),
    .R8out(rout_v[8]),   .R9out(rout_v[9]),   .R10out(rout_v[10]), .R11out(rout_v[11]),
    .R12out(rout_v[12]), .R13out(rout_v[13]), .R14out(rout_v[14]), .R15out(rout_v[15]),
    .R0in(rin_v[0]),     .R1in(rin_v[1]),     .R2in(rin_v[2]),     .R3in(rin_v[3]),
    .R4in(rin_v[4]),     .R5in(rin_v[5]),     .R6in(rin_v[6]),     .R7in(rin_v[7]),
    .R8in(rin_v[8]),     .R9in(rin_v[9]),     .R10in(rin_v[10]),   .R11in(rin_v[11]),
    .R12in(rin_v[12]),   .R13in(rin_v[13]),   .R14in(rin_v[14]),   .R15in(rin_v[15]),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead), .ramEnable(ramEnable),
    .PCin(PCin), .PCout(PCout), .ADD(ADD), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Yin(Yin), .IRin(IRin), .Cout(Cout),
    .InPortData(InPortData), .InPort_Out(InPort_Out), .OutPortData(OutPortData),
    .OutPort_In(OutPort_In), .CONin(CONin), .CON(CON)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {IncPC, Gra, Grb, Grc, Rin, Rout, BAout, MARin, MDRout, MDRin} = '0;
    {memRead, ramEnable, PCin, PCout, ADD, Zin, Zhighout, Zlowout} = '0;
    {HIin, LOin, HIout, LOout, Yin, IRin, Cout, InPort_Out, OutPort_In, CONin} = '0;
    rout_v = '0;
    rin_v  = '0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic drive_in(input logic [31:0] v);
    InPortData = v;
    InPort_Out = 1'b1;
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
    drive_in(addr); MARin = 1'b1; cyc();
    drive_in(data); MDRin = 1'b1; cyc();
    ramEnable = 1'b1; cyc();
  endtask

  task automatic load_ir(input logic [31:0] v);
    drive_in(v); IRin = 1'b1; cyc();
  endtask

  task automatic run_ld();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; cyc();
    memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1; cyc();
    MDRout = 1'b1; IRin = 1'b1; cyc();
    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; cyc();
    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; cyc();
    Zlowout = 1'b1; MARin = 1'b1; cyc();
    memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1; cyc();
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; cyc();
  endtask

  initial begin
    idle();
    InPortData = '0;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", dut.pc, 0);
    check("rst_out", OutPortData, 0);
    check("rst_con", CON, 0);
    clear = 1'b1;

    ram_write(32'h0, 32'h0100_0095);
    ram_write(32'h95, 32'h1234);
    run_ld();
    check("ldb_ir", dut.ir, 64'h0100_0095);
    check("ldb_mar", dut.mar, 64'h95);
    check("ldb_r2", dut.regs[2], 64'h1234);
    check("ldb_pc", dut.pc, 1);

    ram_write(32'h1, 32'h0010_0038);
    ram_write(32'h6C, 32'hCAFE);
    run_ld();
    check("ldx_r0", dut.regs[0], 64'hCAFE);
    check("ldx_pc", dut.pc, 2);
    check("ldx_mar", dut.mar, 64'h126C);

    load_ir(32'h0007_FFFF);
    Cout = 1'b1; #1;
    check("sext_bus", dut.bus, 64'hFFFF_FFFF);
    idle();
    drive_in(32'd5); Yin = 1'b1; cyc();
    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; cyc();
    check("add_zlo", dut.z[31:0], 4);
    check("add_zhi", dut.z[63:32], 0);

    load_ir(32'h0);
    Gra = 1'b1; Rout = 1'b1; #1;
    check("rout_r0", dut.bus, 64'hCAFE);
    idle();
    Gra = 1'b1; BAout = 1'b1; #1;
    check("baout_r0", dut.bus, 0);
    CONin = 1'b1; cyc();
    check("con_eq0", CON, 1);
    load_ir(32'h0008_0000);
    drive_in(32'h0); CONin = 1'b1; cyc();
    check("con_ne0", CON, 0);
    load_ir(32'h0018_0000);
    drive_in(32'h8000_0000); CONin = 1'b1; cyc();
    check("con_neg", CON, 1);
    load_ir(32'h0010_0000);
    drive_in(32'h0); CONin = 1'b1; cyc();
    check("con_pos_zero", CON, 0);
    drive_in(32'd5); CONin = 1'b1; cyc();
    check("con_pos", CON, 1);

    drive_in(32'hA); rin_v[3] = 1'b1; cyc();
    check("inport_r3", dut.regs[3], 64'hA);
    rout_v[3] = 1'b1; OutPort_In = 1'b1; cyc();
    check("outport", OutPortData, 64'hA);

    drive_in(32'h55); MDRin = 1'b1; cyc();
    drive_in(32'h200); MARin = 1'b1; cyc();
    ramEnable = 1'b1; cyc();
    check("ram_wrap", dut.ram[0], 64'h55);

    rout_v[3] = 1'b1; PCout = 1'b1; #1;
    check("bus_prio", dut.bus, 64'hA);
    idle();
    drive_in(32'h77); PCin = 1'b1; IncPC = 1'b1; cyc();
    check("incpc_prio", dut.pc, 3);

    #3;
    clear = 1'b0;
    #1;
    check("arst_pc", dut.pc, 0);
    check("arst_r0", dut.regs[0], 0);
    check("arst_r2", dut.regs[2], 0);
    check("arst_z", dut.z, 0);
    check("arst_out", OutPortData, 0);
    check("arst_con", CON, 0);
    #2;
    clear = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
